// File: rtl/c64_kbd_pkg.sv
// ============================================================================
//  Module      : c64_kbd_pkg
//  Description : Shared types and constants for the C64 keyboard matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package c64_kbd_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXT     = 3'd1,
      BRK     = 3'd2,
      EXT_BRK = 3'd3,
      SKIP    = 3'd4
   } kbd_state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] col;
      logic [2:0] row;
      logic       vshift;
   } keymap_entry_t;

   localparam logic [7:0] PREFIX_E0    = 8'hE0;
   localparam logic [7:0] PREFIX_F0    = 8'hF0;
   localparam logic [7:0] PREFIX_E1    = 8'hE1;
   localparam logic [7:0] RESTORE_CODE = 8'h7D;

   function automatic keymap_entry_t km(input int unsigned col, input int unsigned row,
                                        input int unsigned vshift);
      keymap_entry_t e;
      e.valid  = 1'b1;
      e.col    = 3'(col);
      e.row    = 3'(row);
      e.vshift = (vshift != 0);
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/c64_keymap.sv
// ============================================================================
//  Module      : c64_keymap
//  Description : Combinational PS/2 set-2 {ext, code} to C64 matrix position.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c64_keymap
   import c64_kbd_pkg::*;
(
   input  logic          ext_i,
   input  logic [7:0]    code_i,
   output keymap_entry_t entry_o
);

   always_comb begin
      entry_o = '0;
      case ({ext_i, code_i})
         9'h066: entry_o = km(0, 0, 0);  9'h05A: entry_o = km(0, 1, 0);
         9'h083: entry_o = km(0, 3, 0);  9'h005: entry_o = km(0, 4, 0);
         9'h004: entry_o = km(0, 5, 0);  9'h003: entry_o = km(0, 6, 0);
         9'h026: entry_o = km(1, 0, 0);  9'h01D: entry_o = km(1, 1, 0);
         9'h01C: entry_o = km(1, 2, 0);  9'h025: entry_o = km(1, 3, 0);
         9'h01A: entry_o = km(1, 4, 0);  9'h01B: entry_o = km(1, 5, 0);
         9'h024: entry_o = km(1, 6, 0);  9'h012: entry_o = km(1, 7, 0);
         9'h02E: entry_o = km(2, 0, 0);  9'h02D: entry_o = km(2, 1, 0);
         9'h023: entry_o = km(2, 2, 0);  9'h036: entry_o = km(2, 3, 0);
         9'h021: entry_o = km(2, 4, 0);  9'h02B: entry_o = km(2, 5, 0);
         9'h02C: entry_o = km(2, 6, 0);  9'h022: entry_o = km(2, 7, 0);
         9'h03D: entry_o = km(3, 0, 0);  9'h035: entry_o = km(3, 1, 0);
         9'h034: entry_o = km(3, 2, 0);  9'h03E: entry_o = km(3, 3, 0);
         9'h032: entry_o = km(3, 4, 0);  9'h033: entry_o = km(3, 5, 0);
         9'h03C: entry_o = km(3, 6, 0);  9'h02A: entry_o = km(3, 7, 0);
         9'h046: entry_o = km(4, 0, 0);  9'h043: entry_o = km(4, 1, 0);
         9'h03B: entry_o = km(4, 2, 0);  9'h045: entry_o = km(4, 3, 0);
         9'h03A: entry_o = km(4, 4, 0);  9'h042: entry_o = km(4, 5, 0);
         9'h044: entry_o = km(4, 6, 0);  9'h031: entry_o = km(4, 7, 0);
         9'h055: entry_o = km(5, 0, 0);  9'h04D: entry_o = km(5, 1, 0);
         9'h04B: entry_o = km(5, 2, 0);  9'h04E: entry_o = km(5, 3, 0);
         9'h049: entry_o = km(5, 4, 0);  9'h052: entry_o = km(5, 5, 0);
         9'h054: entry_o = km(5, 6, 0);  9'h041: entry_o = km(5, 7, 0);
         9'h05D: entry_o = km(6, 0, 0);  9'h05B: entry_o = km(6, 1, 0);
         9'h04C: entry_o = km(6, 2, 0);  9'h059: entry_o = km(6, 4, 0);
         9'h04A: entry_o = km(6, 7, 0);
         9'h016: entry_o = km(7, 0, 0);  9'h00E: entry_o = km(7, 1, 0);
         9'h00D: entry_o = km(7, 2, 0);  9'h01E: entry_o = km(7, 3, 0);
         9'h029: entry_o = km(7, 4, 0);  9'h014: entry_o = km(7, 5, 0);
         9'h015: entry_o = km(7, 6, 0);  9'h076: entry_o = km(7, 7, 0);
         // Extended keys; up/left reuse CRSR down/right plus a virtual shift
         9'h172: entry_o = km(0, 7, 0);  9'h174: entry_o = km(0, 2, 0);
         9'h175: entry_o = km(0, 7, 1);  9'h16B: entry_o = km(0, 2, 1);
         9'h16C: entry_o = km(6, 3, 0);  9'h171: entry_o = km(0, 0, 0);
         default: entry_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/c64_keyboard_matrix.sv
// ============================================================================
//  Module      : c64_keyboard_matrix
//  Description : PS/2 decoder, 8x8 C64 key matrix and joystick merge onto CIA1.
//                Optional macro KBD_GHOST_EN adds registered ghost-key closure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c64_keyboard_matrix
   import c64_kbd_pkg::*;
#(
   parameter bit          JOY_SWAP   = 1'b0,
   parameter int unsigned PAUSE_SKIP = 7
) (
   input  logic       clk,
   input  logic       res,
   input  logic       key_strobe,
   input  logic [7:0] key_code,
   input  logic [7:0] pa_out,
   input  logic [7:0] pb_out,
   input  logic [4:0] joy_a,
   input  logic [4:0] joy_b,
   output logic [7:0] pa_in,
   output logic [7:0] pb_in,
   output logic       restore_n
);

   localparam logic [7:0] C_SKIP_LOAD = 8'(PAUSE_SKIP);

   kbd_state_e       state_q, state_d;
   logic [7:0]       skip_q, skip_d;
   logic [7:0][7:0]  key_q, key_d;
   logic [7:0]       vshift_q, vshift_d;
   logic             restore_q, restore_d;
   logic [7:0]       pa_in_q, pa_in_d;
   logic [7:0]       pb_in_q, pb_in_d;

   logic             w_make, w_brk, w_ext, w_is_restore;
   keymap_entry_t    w_entry;
   logic [7:0][7:0]  w_mat, w_pin_mat;
   logic [7:0]       w_pa_drv, w_pb_drv;
   logic [4:0]       w_joy_pa, w_joy_pb;
   logic [7:0]       w_jpa8, w_jpb8;
   logic             w_hit_r, w_hit_c;

   assign w_ext        = (state_q == EXT) || (state_q == EXT_BRK);
   assign w_is_restore = w_ext && (key_code == RESTORE_CODE);

   c64_keymap u_keymap (
      .ext_i   (w_ext),
      .code_i  (key_code),
      .entry_o (w_entry)
   );

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      w_make  = 1'b0;
      w_brk   = 1'b0;
      if (key_strobe) begin
         case (state_q)
            IDLE: begin
               if (key_code == PREFIX_E0) begin
                  state_d = EXT;
               end else if (key_code == PREFIX_F0) begin
                  state_d = BRK;
               end else if (key_code == PREFIX_E1) begin
                  if (PAUSE_SKIP != 0) begin
                     state_d = SKIP;
                     skip_d  = C_SKIP_LOAD;
                  end
               end else begin
                  w_make = 1'b1;
               end
            end
            EXT: begin
               if (key_code == PREFIX_F0) begin
                  state_d = EXT_BRK;
               end else begin
                  w_make  = 1'b1;
                  state_d = IDLE;
               end
            end
            BRK, EXT_BRK: begin
               w_brk   = 1'b1;
               state_d = IDLE;
            end
            SKIP: begin
               skip_d = skip_q - 8'd1;
               if (skip_q <= 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Composite keys own a per-row virtual shift bit so a physical shift break leaves it intact
   always_comb begin
      key_d     = key_q;
      vshift_d  = vshift_q;
      restore_d = restore_q;
      if (w_make || w_brk) begin
         if (w_is_restore) begin
            restore_d = w_make;
         end else if (w_entry.valid) begin
            key_d[w_entry.col][w_entry.row] = w_make;
            if (w_entry.vshift) vshift_d[w_entry.row] = w_make;
         end
      end
   end

   always_comb begin
      w_mat       = key_q;
      w_mat[6][4] = key_q[6][4] | (|vshift_q);
   end

   assign w_joy_pb = JOY_SWAP ? joy_b : joy_a;
   assign w_joy_pa = JOY_SWAP ? joy_a : joy_b;

`ifdef KBD_GHOST_EN
   logic [7:0][7:0] w_closure, eff_q;
   logic [7:0]      pa_s_q, pb_s_q;
   logic [4:0]      jpa_s_q, jpb_s_q;

   always_comb begin
      w_closure = w_mat;
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < 8; r++) begin
            for (int c2 = 0; c2 < 8; c2++) begin
               for (int r2 = 0; r2 < 8; r2++) begin
                  w_closure[c][r] = w_closure[c][r] |
                                    (w_mat[c][r2] & w_mat[c2][r2] & w_mat[c2][r]);
               end
            end
         end
      end
   end

   // Port drive is delayed alongside the closure so both paths stay aligned
   always_ff @(posedge clk) begin
      if (res) begin
         eff_q   <= '0;
         pa_s_q  <= '1;
         pb_s_q  <= '1;
         jpa_s_q <= '1;
         jpb_s_q <= '1;
      end else begin
         eff_q   <= w_closure;
         pa_s_q  <= pa_out;
         pb_s_q  <= pb_out;
         jpa_s_q <= w_joy_pa;
         jpb_s_q <= w_joy_pb;
      end
   end

   assign w_pin_mat = eff_q;
   assign w_pa_drv  = pa_s_q;
   assign w_pb_drv  = pb_s_q;
   assign w_jpa8    = {3'b111, jpa_s_q};
   assign w_jpb8    = {3'b111, jpb_s_q};
`else
   assign w_pin_mat = w_mat;
   assign w_pa_drv  = pa_out;
   assign w_pb_drv  = pb_out;
   assign w_jpa8    = {3'b111, w_joy_pa};
   assign w_jpb8    = {3'b111, w_joy_pb};
`endif

   always_comb begin
      pa_in_d = '1;
      pb_in_d = '1;
      w_hit_r = 1'b0;
      w_hit_c = 1'b0;
      for (int r = 0; r < 8; r++) begin
         w_hit_r = 1'b0;
         for (int c = 0; c < 8; c++) w_hit_r = w_hit_r | (w_pin_mat[c][r] & ~w_pa_drv[c]);
         pb_in_d[r] = w_pb_drv[r] & ~w_hit_r & w_jpb8[r];
      end
      for (int c = 0; c < 8; c++) begin
         w_hit_c = 1'b0;
         for (int r = 0; r < 8; r++) w_hit_c = w_hit_c | (w_pin_mat[c][r] & ~w_pb_drv[r]);
         pa_in_d[c] = w_pa_drv[c] & ~w_hit_c & w_jpa8[c];
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= IDLE;
         skip_q    <= '0;
         key_q     <= '0;
         vshift_q  <= '0;
         restore_q <= 1'b0;
         pa_in_q   <= '1;
         pb_in_q   <= '1;
      end else begin
         state_q   <= state_d;
         skip_q    <= skip_d;
         key_q     <= key_d;
         vshift_q  <= vshift_d;
         restore_q <= restore_d;
         pa_in_q   <= pa_in_d;
         pb_in_q   <= pb_in_d;
      end
   end

   assign pa_in     = pa_in_q;
   assign pb_in     = pb_in_q;
   assign restore_n = ~restore_q;

endmodule

`default_nettype wire
